instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage of the 9-bit UAZ microprocessor. Holds the program counter, requests instruction words from instruction memory over a request/acknowledge handshake, and presents the fetched 9-bit word (opcode[8:6], RX[5:3], RY[2:0]) to the decode stage with a valid/stall handshake. Accepts branch redirects from execute.

## Interface
- ADDR_W, 8, program counter and instruction memory address width
- INSTR_W, 9, instruction word width; the design supports only 9
- RESET_PC, 0, program counter value after reset

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  instruction memory read request
- imem_addr  out  ADDR_W  read address, equals pc while imem_req=1
- imem_ack  in  1  memory read data valid this cycle
- imem_rdata  in  INSTR_W  instruction word, valid when imem_ack=1
- stall  in  1  decode cannot accept the presented instruction
- branch_en  in  1  redirect fetch this cycle
- branch_target  in  ADDR_W  redirect address
- Instruction  out  INSTR_W  registered instruction word for decode
- instr_valid  out  1  Instruction is valid and not yet consumed
- pc  out  ADDR_W  address of the next word to fetch
- halted  out  1  fetch stopped on halt word

## Operation
- States: FETCH, HOLD, HALT.
- FETCH: imem_req=1 and imem_addr=pc, both combinational from state. On imem_ack=1: Instruction<=imem_rdata, instr_valid<=1, pc<=pc+1, next state HOLD. On imem_ack=0: remain in FETCH, request held.
- HOLD: imem_req=0 and instr_valid=1. On stall=1: Instruction and instr_valid hold. On stall=0, decode consumes the word this cycle: instr_valid<=0, next state FETCH.
- pc increments modulo 2^ADDR_W; 2^ADDR_W−1 wraps to 0 with no flag.
- branch_en=1 has priority in every state, including over stall and over a coincident imem_ack. Effects: pc<=branch_target, instr_valid<=0, next state FETCH. The acknowledged word is discarded and the pc increment is suppressed.
- Reset, including mid-request: state<=FETCH, pc<=RESET_PC, Instruction<=0, instr_valid<=0, halted<=0. imem_req is forced to 0 while rst=1. The memory must drop any in-flight ack on reset.

## Timing
- Best-case throughput: one instruction every 2 cycles, i.e. ack in the first FETCH cycle plus a HOLD cycle with stall=0.
- Latency: imem_ack at edge N gives instr_valid=1 from N+1.
- Each additional cycle without ack or with stall=1 adds one cycle.
- Branch asserted at edge N: instr_valid=0 and imem_addr=branch_target from N+1.
- The memory must not assert imem_ack while imem_req=0. The stage ignores any such ack.

## Configuration
- FETCH_HALT_EN defined: a captured word equal to 9'h1FF (opcode 3'b111, RX=7, RY=7) moves the stage to HALT instead of HOLD.
  - In HALT: instr_valid=0, imem_req=0, halted=1, pc=address after the halt word.
  - Exit only by rst, or by branch_en, which clears halted and goes to FETCH.
- FETCH_HALT_EN undefined: 9'h1FF is an ordinary instruction, the HALT state is not built, halted is tied to 0.

## Structure
- Package fetch_pkg contains the state enum (FETCH, HOLD, HALT), the INSTR_W constant, and HALT_WORD=9'h1FF.
- One sub-module, pc_counter, contains the pc register and its load, increment, and reset logic, controlled by inc and load strobes from the FSM.
- The top level contains the FSM and the instruction register.

## Test plan
- Reset, then memory acks the same cycle with 9'h0A5 at address 0 and stall=0. Required: Instruction=9'h0A5 and instr_valid=1 for exactly one cycle, then imem_addr=1.
- Ack delayed 3 cycles. Required: imem_req and imem_addr=0 held 4 cycles, then instr_valid=1.
- stall=1 for 5 cycles in HOLD. Required: Instruction stable, imem_req=0, pc unchanged.
- branch_en with target 8'h40 in the same cycle as imem_ack. Required: word discarded, instr_valid=0, next imem_addr=8'h40.
- Start with pc=8'hFF. Required: after fetch, pc=8'h00.
- With FETCH_HALT_EN, fetch 9'h1FF. Required: halted=1, imem_req=0 indefinitely. Then a branch to 8'h10 resumes fetch. Without the macro, 9'h1FF is presented with instr_valid=1.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the UAZ instruction fetch stage.
package fetch_pkg;

  localparam int unsigned INSTR_W = 9;
  localparam logic [INSTR_W-1:0] HALT_WORD = 9'h1FF;

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    HALT
  } state_t;

endpackage

// File: rtl/pc_counter.sv
// Program counter register: synchronous reset, branch load, modulo-2^ADDR_W increment.
module pc_counter #(
  parameter int unsigned       ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              load,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc
);

  // Load wins over increment so a redirect suppresses the step of a coincident fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= target;
    end else if (inc) begin
      pc <= pc + 1'b1;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// UAZ instruction fetch stage: pc, memory handshake, instruction register for decode.
// Optional halt-on-9'h1FF behaviour is enabled by defining FETCH_HALT_EN.
module instr_fetch #(
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       INSTR_W  = 9,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               branch_en,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [INSTR_W-1:0] Instruction,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted
);

  import fetch_pkg::*;

  state_t state, state_next;
  logic   pc_inc;
  logic   pc_load;
  logic   capture;

  pc_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_counter (
    .clk    (clk),
    .rst    (rst),
    .inc    (pc_inc),
    .load   (pc_load),
    .target (branch_target),
    .pc     (pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    capture    = 1'b0;
    unique case (state)
      FETCH: begin
        if (branch_en) begin
          pc_load = 1'b1;
        end else if (imem_ack) begin
          capture    = 1'b1;
          pc_inc     = 1'b1;
          state_next = HOLD;
`ifdef FETCH_HALT_EN
          if (imem_rdata == HALT_WORD) begin
            state_next = HALT;
          end
`endif
        end
      end
      HOLD: begin
        if (branch_en) begin
          pc_load    = 1'b1;
          state_next = FETCH;
        end else if (!stall) begin
          state_next = FETCH;
        end
      end
`ifdef FETCH_HALT_EN
      HALT: begin
        if (branch_en) begin
          pc_load    = 1'b1;
          state_next = FETCH;
        end
      end
`endif
      default: state_next = FETCH;
    endcase
  end

  // Capture is gated by branch_en above, so a word acked alongside a redirect is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      Instruction <= '0;
    end else if (capture) begin
      Instruction <= imem_rdata;
    end
  end

  // instr_valid is a decode of the registered state: HOLD is exactly "word presented".
  assign instr_valid = (state == HOLD);
  assign imem_req    = (state == FETCH) && !rst;
  assign imem_addr   = pc;

`ifdef FETCH_HALT_EN
  assign halted = (state == HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed fetches, stalls, branches, wrap and halt word.
module tb_instr_fetch;

  logic       clk = 1'b0;
  logic       rst;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack;
  logic [8:0] imem_rdata;
  logic       stall;
  logic       branch_en;
  logic [7:0] branch_target;
  logic [8:0] Instruction;
  logic       instr_valid;
  logic [7:0] pc;
  logic       halted;

  int total = 0;
  int bad   = 0;
  logic [8:0] exp_q[$];

  instr_fetch #(
    .ADDR_W   (8),
    .INSTR_W  (9),
    .RESET_PC (8'h00)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .branch_en     (branch_en),
    .branch_target (branch_target),
    .Instruction   (Instruction),
    .instr_valid   (instr_valid),
    .pc            (pc),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every word decode consumes must be the next expected word.
  always @(negedge clk) begin
    if (!rst && instr_valid && !stall && !branch_en) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", {23'd0, Instruction}, 32'h0);
        total--;
        bad++;
        $display("FAIL unexpected_consume: word %0h with empty scoreboard", Instruction);
      end else begin
        chk("consumed_word", {23'd0, Instruction}, {23'd0, exp_q.pop_front()});
      end
    end
  end

  // Called just after a rising edge with the DUT in FETCH at exp_addr.
  task automatic do_fetch(input logic [8:0] w, input int delay, input int stalls,
                          input logic [7:0] exp_addr, input logic [7:0] exp_next);
    for (int i = 0; i < delay; i++) begin
      imem_ack = 1'b0;
      @(negedge clk);
      chk("wait_req", {31'd0, imem_req}, 32'd1);
      chk("wait_addr", {24'd0, imem_addr}, {24'd0, exp_addr});
      @(posedge clk); #1;
    end
    imem_ack   = 1'b1;
    imem_rdata = w;
    stall      = (stalls > 0);
    exp_q.push_back(w);
    @(negedge clk);
    chk("ack_req", {31'd0, imem_req}, 32'd1);
    chk("ack_addr", {24'd0, imem_addr}, {24'd0, exp_addr});
    chk("ack_valid_low", {31'd0, instr_valid}, 32'd0);
    @(posedge clk); #1;
    for (int s = 0; s < stalls; s++) begin
      stall      = 1'b1;
      imem_ack   = 1'b1;      // stray ack while not requesting must be ignored
      imem_rdata = 9'h1AB;
      @(negedge clk);
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_instr", {23'd0, Instruction}, {23'd0, w});
      chk("stall_req", {31'd0, imem_req}, 32'd0);
      chk("stall_pc", {24'd0, pc}, {24'd0, exp_next});
      @(posedge clk); #1;
    end
    imem_ack = 1'b0;
    stall    = 1'b0;
    @(negedge clk);
    chk("hold_valid", {31'd0, instr_valid}, 32'd1);
    chk("hold_instr", {23'd0, Instruction}, {23'd0, w});
    chk("hold_req", {31'd0, imem_req}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("after_valid", {31'd0, instr_valid}, 32'd0);
    chk("after_req", {31'd0, imem_req}, 32'd1);
    chk("after_addr", {24'd0, imem_addr}, {24'd0, exp_next});
    chk("after_pc", {24'd0, pc}, {24'd0, exp_next});
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_ack = 1'b0;
    stall = 1'b0;
    branch_en = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", {23'd0, Instruction}, 32'd0);
    chk("rst_pc", {24'd0, pc}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    imem_ack = 1'b0;
    imem_rdata = '0;
    stall = 1'b0;
    branch_en = 1'b0;
    branch_target = '0;

    // Back-to-back: ack in the first FETCH cycle after reset.
    do_reset();
    do_fetch(9'h0A5, 0, 0, 8'h00, 8'h01);

    // Reset mid-request, then delayed ack.
    imem_ack = 1'b1;
    imem_rdata = 9'h0EE;
    do_reset();
    do_fetch(9'h123, 3, 0, 8'h00, 8'h01);

    // Decode stall for 5 cycles.
    do_fetch(9'h0F0, 0, 5, 8'h01, 8'h02);

    // Branch coincident with ack: word dropped, no increment.
    imem_ack = 1'b1;
    imem_rdata = 9'h155;
    branch_en = 1'b1;
    branch_target = 8'h40;
    @(negedge clk);
    @(posedge clk); #1;
    imem_ack = 1'b0;
    branch_en = 1'b0;
    @(negedge clk);
    chk("br_valid", {31'd0, instr_valid}, 32'd0);
    chk("br_req", {31'd0, imem_req}, 32'd1);
    chk("br_addr", {24'd0, imem_addr}, 32'h40);
    @(posedge clk); #1;
    do_fetch(9'h0C3, 0, 0, 8'h40, 8'h41);

    // Branch over a stalled word in HOLD.
    imem_ack = 1'b1;
    imem_rdata = 9'h077;
    stall = 1'b1;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    branch_en = 1'b1;
    branch_target = 8'hFF;
    @(negedge clk);
    chk("hold_br_valid", {31'd0, instr_valid}, 32'd1);
    @(posedge clk); #1;
    branch_en = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    chk("hold_br_valid_low", {31'd0, instr_valid}, 32'd0);
    chk("hold_br_addr", {24'd0, imem_addr}, 32'hFF);
    @(posedge clk); #1;

    // pc wraps from FF to 00.
    do_fetch(9'h042, 0, 0, 8'hFF, 8'h00);

`ifdef FETCH_HALT_EN
    imem_ack = 1'b1;
    imem_rdata = 9'h1FF;
    @(posedge clk); #1;
    imem_rdata = 9'h0AA;      // stray acks during halt must be ignored
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("halt_flag", {31'd0, halted}, 32'd1);
      chk("halt_req", {31'd0, imem_req}, 32'd0);
      chk("halt_valid", {31'd0, instr_valid}, 32'd0);
      chk("halt_pc", {24'd0, pc}, 32'h01);
      @(posedge clk); #1;
    end
    imem_ack = 1'b0;
    branch_en = 1'b1;
    branch_target = 8'h10;
    @(posedge clk); #1;
    branch_en = 1'b0;
    @(negedge clk);
    chk("resume_halted", {31'd0, halted}, 32'd0);
    chk("resume_req", {31'd0, imem_req}, 32'd1);
    chk("resume_addr", {24'd0, imem_addr}, 32'h10);
    @(posedge clk); #1;
    do_fetch(9'h011, 0, 0, 8'h10, 8'h11);
`else
    do_fetch(9'h1FF, 0, 0, 8'h00, 8'h01);
    @(negedge clk);
    chk("no_halt_flag", {31'd0, halted}, 32'd0);
    @(posedge clk); #1;
`endif

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
